// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per cycle LSB first through a single 1-bit cell.
// Latency WIDTH cycles from accepted start to the one-cycle done pulse; start is ignored while busy.
module serial_sub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bflop_q, bflop_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             x, y, bin;
  logic             d1, b1, d, b2, bout;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] res_next;

  // 1-bit subtract cell: two half-subtractors with the borrows ORed.
  assign x    = a_sr_q[0];
  assign y    = b_sr_q[0];
  assign bin  = bflop_q;
  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

  // New bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  assign res_next = (r_sr_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last_bit = (cnt_q == CNT_LAST);
  assign accept   = (state_q != BUSY) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last_bit) state_d = DONE;
      DONE:    state_d = start ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == BUSY);
    done = (state_q == DONE);
  end

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bflop_d  = bflop_q;
    cnt_d    = cnt_q;
    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = b;
      bflop_d = 1'b0;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      r_sr_d  = res_next;
      bflop_d = bout;
      if (last_bit) begin
        diff_d   = res_next;
        borrow_d = bout;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bflop_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bflop_q  <= bflop_d;
      cnt_q    <= cnt_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH 4, 1 and 8.
module tb_serial_sub_ctrl;

  logic clk;
  logic rst;

  logic       start4, busy4, done4, borrow4;
  logic [3:0] a4, b4, diff4;
  logic       start1, busy1, done1, borrow1;
  logic [0:0] a1, b1, diff1;
  logic       start8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;

  int checks;
  int failures;

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );
  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );
  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  always #5 clk = ~clk;

  // Every task begins and ends at a falling edge; inputs change and outputs are sampled there.
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags4: busy=%b done=%b, want 0 0", busy4, done4);
    end
    checks++;
    if (diff4 !== 4'h0 || borrow4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_result4: diff=%h borrow=%b, want 0 0", diff4, borrow4);
    end
    checks++;
    if ({busy1, done1, diff1, borrow1} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_w1: busy/done/diff/borrow=%b, want 0000", {busy1, done1, diff1, borrow1});
    end
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'h0) begin
      failures++;
      $display("FAIL reset_w8: busy/done/diff/borrow=%h, want 0", {busy8, done8, diff8, borrow8});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] va [4] = '{4'b0110, 4'b0011, 4'b1111, 4'b0000};
    logic [3:0] vb [4] = '{4'b0011, 4'b0110, 4'b1111, 4'b0001};
    logic [3:0] vd [4] = '{4'b0011, 4'b1101, 4'b0000, 4'b1111};
    logic       vr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int bad;
    for (int t = 0; t < 4; t++) begin
      start4 = 1'b1; a4 = va[t]; b4 = vb[t];
      bad = 0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        start4 = 1'b0;
        if (busy4 !== 1'b1 || done4 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL basic_busy[%0d]: %0d of 4 busy cycles wrong, want 0", t, bad);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b1 || busy4 !== 1'b0) begin
        failures++;
        $display("FAIL basic_done[%0d]: done=%b busy=%b, want 1 0", t, done4, busy4);
      end
      checks++;
      if (diff4 !== vd[t] || borrow4 !== vr[t]) begin
        failures++;
        $display("FAIL basic_result[%0d]: diff=%b borrow=%b, want %b %b", t, diff4, borrow4, vd[t], vr[t]);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0) begin
        failures++;
        $display("FAIL basic_pulse[%0d]: done=%b busy=%b, want 0 0", t, done4, busy4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va, vb;
    logic [3:0] op_a [3];
    logic [3:0] op_b [3];
    logic       exp_busy, exp_done;
    logic [3:0] exp_diff;
    logic       exp_bor;
    int         op;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 1) begin
        exp_busy = (i >= 1 && i <= 4) || (i >= 6 && i <= 9) || (i >= 11 && i <= 14);
        exp_done = (i == 5) || (i == 10) || (i == 15);
        checks++;
        if (busy4 !== exp_busy || done4 !== exp_done) begin
          failures++;
          $display("FAIL b2b_flags@%0d: busy=%b done=%b, want %b %b", i, busy4, done4, exp_busy, exp_done);
        end
        if (exp_done) begin
          op = i / 5 - 1;
          exp_diff = op_a[op] - op_b[op];
          exp_bor  = (op_a[op] < op_b[op]);
          checks++;
          if (diff4 !== exp_diff || borrow4 !== exp_bor) begin
            failures++;
            $display("FAIL b2b_result[%0d]: diff=%h borrow=%b, want %h %b", op, diff4, borrow4, exp_diff, exp_bor);
          end
        end
      end
      va = 4'((i * 3 + 5) % 16);
      vb = 4'((i * 7 + 2) % 16);
      if (i == 0 || i == 5 || i == 10) begin
        op_a[i / 5] = va;
        op_b[i / 5] = vb;
      end
      start4 = (i < 12);
      a4 = va; b4 = vb;
    end
  endtask

  task automatic test_ignore_start();
    start4 = 1'b1; a4 = 4'b0110; b4 = 4'b0011;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); start4 = 1'b1; a4 = 4'b1111; b4 = 4'b0000;
    @(negedge clk); start4 = 1'b0; a4 = 4'b1001; b4 = 4'b0111;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) begin
      failures++;
      $display("FAIL ignore_busy: busy=%b, want 1", busy4);
    end
    @(negedge clk);
    checks++;
    if (done4 !== 1'b1 || diff4 !== 4'b0011 || borrow4 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result: done=%b diff=%b borrow=%b, want 1 0011 0", done4, diff4, borrow4);
    end
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_idle: busy=%b done=%b, want 0 0", busy4, done4);
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd9;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 4'h0 || borrow4 !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear: busy=%b done=%b diff=%h borrow=%b, want 0 0 0 0", busy4, done4, diff4, borrow4);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done4 !== 1'b0 || busy4 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d cycles with busy/done set, want 0", bad);
    end
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd5;
    @(negedge clk); start4 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done4 !== 1'b1 || diff4 !== 4'd4 || borrow4 !== 1'b0) begin
      failures++;
      $display("FAIL abort_recover: done=%b diff=%h borrow=%b, want 1 4 0", done4, diff4, borrow4);
    end
    @(negedge clk);
  endtask

  task automatic test_width1();
    logic [1:0] exp [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
    for (int t = 0; t < 4; t++) begin
      start1 = 1'b1; a1 = 1'(t >> 1); b1 = 1'(t & 1);
      @(negedge clk); start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        failures++;
        $display("FAIL w1_busy[%0d]: busy=%b done=%b, want 1 0", t, busy1, done1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || {diff1, borrow1} !== exp[t]) begin
        failures++;
        $display("FAIL w1_result[%0d]: done=%b diff,borrow=%b%b, want 1 %b", t, done1, diff1, borrow1, exp[t]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random8();
    logic [8:0] exp;
    int         wait_cyc;
    for (int n = 0; n < 1000; n++) begin
      start8 = 1'b1;
      a8 = 8'($urandom_range(255));
      b8 = 8'($urandom_range(255));
      exp = {1'b0, a8} - {1'b0, b8};
      @(negedge clk); start8 = 1'b0;
      wait_cyc = 0;
      while (done8 !== 1'b1 && wait_cyc < 20) begin
        @(negedge clk);
        wait_cyc++;
      end
      checks++;
      if (done8 !== 1'b1) begin
        failures++;
        $display("FAIL rand8_timeout[%0d]: done=%b after %0d cycles, want 1", n, done8, wait_cyc);
      end else if (wait_cyc != 8 || {borrow8, diff8} !== exp) begin
        failures++;
        $display("FAIL rand8[%0d]: latency=%0d borrow,diff=%h, want 9 %h", n, wait_cyc + 1, {borrow8, diff8}, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_width1();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
